rca_lsq_responder: RTL

Responder end of the RCA operation-unit (OU) load/store interface.
- Accepts load/store requests from one OU into an in-order FIFO.
- Issues them one at a time to a word-addressed memory port.
- Returns formatted load results to the OU.
- Handles sub-word alignment: byte enables and lane replication for stores, lane extraction and sign/zero extension for loads.

---
 rtl/rca_lsq_responder.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/rca_lsq_responder.sv
// Responder end of the RCA OU load/store interface: in-order request FIFO,
// single-outstanding word memory port, sub-word store/load formatting.
// Optional macro RCA_LSQ_MISALIGN_CHECK_EN drops misaligned H/W accesses at the head.
//
// Memory handshake: a request transfers on a cycle where mem_req && mem_ack;
// mem_addr/mem_we/mem_be/mem_wdata are stable while mem_req is high and
// unacknowledged. mem_rvalid is only honoured while a load is outstanding.
module rca_lsq_responder #(
  parameter int LSQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  input  logic [2:0]  fn3,
  input  logic        load,
  input  logic        store,
  input  logic        new_request,
  output logic        lsq_full,
  output logic [31:0] load_data,
  output logic        load_complete,
  output logic        misalign_err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        mem_we,
  input  logic        mem_ack,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int PTR_W = $clog2(LSQ_DEPTH);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  fn3;
    logic        is_load;
  } entry_t;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t           state_q, state_d;
  entry_t           fifo_q [LSQ_DEPTH];
  entry_t           fifo_d [LSQ_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [2:0]       wfn3_q, wfn3_d;
  logic [1:0]       woff_q, woff_d;
  logic [31:0]      load_data_q, load_data_d;
  logic             load_complete_q, load_complete_d;
  logic             misalign_err_q, misalign_err_d;

  entry_t      head;
  logic [1:0]  head_off;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic        head_misaligned;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_fmt;

  assign head       = fifo_q[rd_ptr_q];
  assign head_off   = head.addr[1:0];
  assign fifo_empty = (count_q == '0);
  assign lsq_full   = (count_q == (PTR_W+1)'(LSQ_DEPTH));
  assign push       = new_request && !lsq_full && (load || store);

`ifdef RCA_LSQ_MISALIGN_CHECK_EN
  assign head_misaligned = ((head.fn3[1:0] == 2'b01) && head_off[0]) ||
                           (head.fn3[1] && (head_off != 2'b00));
`else
  assign head_misaligned = 1'b0;
`endif

  assign mem_req = (state_q == S_IDLE) && !fifo_empty && !head_misaligned;
  // A misaligned head is retired locally without touching the memory port.
  assign pop     = (mem_req && mem_ack) ||
                   ((state_q == S_IDLE) && !fifo_empty && head_misaligned);

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = head.data;
    case (head.fn3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << head_off;
        st_wdata = {4{head.data[7:0]}};
      end
      2'b01: begin
        st_be    = head_off[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{head.data[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = head.data;
      end
    endcase
  end

  assign mem_addr  = {head.addr[31:2], 2'b00};
  assign mem_we    = !head.is_load;
  assign mem_be    = head.is_load ? 4'b1111 : st_be;
  assign mem_wdata = st_wdata;

  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (woff_q)
      2'b00:   ld_byte = mem_rdata[7:0];
      2'b01:   ld_byte = mem_rdata[15:8];
      2'b10:   ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = woff_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_fmt  = mem_rdata;
    case (wfn3_q[1:0])
      2'b00:   ld_fmt = {{24{!wfn3_q[2] && ld_byte[7]}}, ld_byte};
      2'b01:   ld_fmt = {{16{!wfn3_q[2] && ld_half[15]}}, ld_half};
      default: ld_fmt = mem_rdata;
    endcase
  end

  always_comb begin
    fifo_d          = fifo_q;
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    count_d         = count_q;
    state_d         = state_q;
    wfn3_d          = wfn3_q;
    woff_d          = woff_q;
    load_data_d     = load_data_q;
    load_complete_d = 1'b0;
    misalign_err_d  = 1'b0;

    if (push) begin
      fifo_d[wr_ptr_q] = '{addr: addr, data: data, fn3: fn3, is_load: load};
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          if (head_misaligned) begin
            misalign_err_d = 1'b1;
            if (head.is_load) begin
              load_complete_d = 1'b1;
              load_data_d     = 32'h0;
            end
          end else if (head.is_load) begin
            state_d = S_WAIT;
            wfn3_d  = head.fn3;
            woff_d  = head_off;
          end
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          load_data_d     = ld_fmt;
          load_complete_d = 1'b1;
          state_d         = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      count_q         <= '0;
      wfn3_q          <= 3'b000;
      woff_q          <= 2'b00;
      load_data_q     <= 32'h0;
      load_complete_q <= 1'b0;
      misalign_err_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
      wfn3_q          <= wfn3_d;
      woff_q          <= woff_d;
      load_data_q     <= load_data_d;
      load_complete_q <= load_complete_d;
      misalign_err_q  <= misalign_err_d;
    end
  end

  // Entry payload needs no reset: count_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LSQ_DEPTH; i++) begin
      fifo_q[i] <= fifo_d[i];
    end
  end

  assign load_data     = load_data_q;
  assign load_complete = load_complete_q;
  assign misalign_err  = misalign_err_q;

endmodule
